// File: rtl/divide1_if.sv
// Start/done/err handshake and operand/result bus between a controller and the divider.
interface divide1_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] dividen;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             done;
  logic             sign;
  logic             err;

  modport master (output start, dividen, divisor, input Q, R, done, sign, err);
  modport slave  (input start, dividen, divisor, output Q, R, done, sign, err);
endinterface

// File: rtl/divide1_top.sv
// Iterative signed restoring divider, one quotient bit per clock; C-style truncated Q,
// remainder takes the dividend's sign. Divide-by-zero and MIN/-1 report err instead.
module divide1_top #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  divide1_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_ITER, S_FIX, S_DONE, S_ERR} state_t;

  state_t           r_state, w_next;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo, r_dvs, r_raw, r_q, r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_sign, r_dneg, r_done, r_err;

  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_min;
  logic             w_bad, w_ge;
  logic [WIDTH+1:0] w_shrem;
  logic [WIDTH:0]   w_diff;

  always_comb begin
    w_min   = {1'b1, {(WIDTH-1){1'b0}}};
    // |MIN| wraps to MIN, which is exactly 2^(W-1) when read as unsigned
    w_abs_a = bus.dividen[WIDTH-1] ? -bus.dividen : bus.dividen;
    w_abs_b = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
    w_bad   = (bus.divisor == '0) || ((bus.dividen == w_min) && (bus.divisor == '1));
    w_shrem = {r_rem, r_quo[WIDTH-1]};
    w_ge    = (w_shrem >= {2'b00, r_dvs});
    // when w_ge holds the difference is below |divisor|, so W+1 bits suffice
    w_diff  = w_shrem[WIDTH:0] - {1'b0, r_dvs};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = w_bad ? S_ERR : S_ITER;
      S_ITER: if (r_cnt == CW'(1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      S_ERR:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_raw  <= '0;
      r_cnt  <= '0;
      r_sign <= 1'b0;
      r_dneg <= 1'b0;
      r_q    <= '0;
      r_r    <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      // pulses are registered off the DONE/ERR states, so they land one edge later
      r_done <= (r_state == S_DONE);
      r_err  <= (r_state == S_ERR);
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_quo  <= w_abs_a;
          r_dvs  <= w_abs_b;
          r_raw  <= bus.dividen;
          r_rem  <= '0;
          r_cnt  <= CW'(WIDTH);
          r_sign <= bus.dividen[WIDTH-1] ^ bus.divisor[WIDTH-1];
          r_dneg <= bus.dividen[WIDTH-1];
        end
        S_ITER: begin
          if (w_ge) begin
            r_rem <= w_diff;
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_shrem[WIDTH:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_q <= r_sign ? -r_quo : r_quo;
          r_r <= r_dneg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
        end
        S_ERR: begin
          r_q <= '1;
          r_r <= r_raw;
        end
        default: ;
      endcase
    end
  end

  assign bus.Q    = r_q;
  assign bus.R    = r_r;
  assign bus.done = r_done;
  assign bus.err  = r_err;
  assign bus.sign = r_sign;
endmodule

// File: tb/tb_divide1_top.sv
// Directed bench for divide1_top (WIDTH=8): signs, boundaries, errors, abort, back-to-back.
module tb_divide1_top;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  divide1_if #(.WIDTH(8)) bus ();
  divide1_top #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Launch one operation; wait (bounded) for done or err, reporting the edge count after accept.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic got_done, output logic got_err, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.dividen = a; bus.divisor = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.dividen = 8'($urandom); bus.divisor = 8'($urandom);
    got_done = 1'b0; got_err = 1'b0; lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.done || bus.err) begin
        got_done = bus.done; got_err = bus.err; lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (bus.Q !== 8'h00)  begin n_fail++; $display("FAIL reset_Q got %h want 00", bus.Q); end
    n_tests++; if (bus.R !== 8'h00)  begin n_fail++; $display("FAIL reset_R got %h want 00", bus.R); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_tests++; if (bus.err !== 1'b0)  begin n_fail++; $display("FAIL reset_err got %b want 0", bus.err); end
    n_tests++; if (bus.sign !== 1'b0) begin n_fail++; $display("FAIL reset_sign got %b want 0", bus.sign); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_signs();
    logic [7:0] a [7], b [7], eq [7], er [7];
    logic       es [7];
    logic d, e; int lat;
    a = '{8'hCB, 8'h35, 8'h35, 8'hCB, 8'h80, 8'h7F, 8'h03};
    b = '{8'h05, 8'h05, 8'hFB, 8'hFB, 8'h01, 8'h7F, 8'h07};
    eq = '{8'hF6, 8'h0A, 8'hF6, 8'h0A, 8'h80, 8'h01, 8'h00};
    er = '{8'hFD, 8'h03, 8'h03, 8'hFD, 8'h00, 8'h00, 8'h03};
    es = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      run_op(a[i], b[i], d, e, lat);
      n_tests++; if (!(d === 1'b1 && e === 1'b0 && lat == 10))
        begin n_fail++; $display("FAIL div%0d_done done=%b err=%b lat=%0d want done=1 err=0 lat=10", i, d, e, lat); end
      n_tests++; if (bus.Q !== eq[i]) begin n_fail++; $display("FAIL div%0d_Q got %h want %h", i, bus.Q, eq[i]); end
      n_tests++; if (bus.R !== er[i]) begin n_fail++; $display("FAIL div%0d_R got %h want %h", i, bus.R, er[i]); end
      n_tests++; if (bus.sign !== es[i]) begin n_fail++; $display("FAIL div%0d_sign got %b want %b", i, bus.sign, es[i]); end
      @(posedge clk); #1;
      n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL div%0d_pulse done still %b want 0", i, bus.done); end
      n_tests++; if (bus.Q !== eq[i]) begin n_fail++; $display("FAIL div%0d_hold Q got %h want %h", i, bus.Q, eq[i]); end
    end
  endtask

  task automatic test_err();
    logic [7:0] a [2], b [2], er [2];
    logic d, e; int lat, extra;
    a = '{8'h07, 8'h80};
    b = '{8'h00, 8'hFF};
    er = '{8'h07, 8'h80};
    for (int i = 0; i < 2; i++) begin
      run_op(a[i], b[i], d, e, lat);
      n_tests++; if (!(e === 1'b1 && d === 1'b0))
        begin n_fail++; $display("FAIL err%0d_flag err=%b done=%b want err=1 done=0", i, e, d); end
      n_tests++; if (bus.Q !== 8'hFF) begin n_fail++; $display("FAIL err%0d_Q got %h want ff", i, bus.Q); end
      n_tests++; if (bus.R !== er[i]) begin n_fail++; $display("FAIL err%0d_R got %h want %h", i, bus.R, er[i]); end
      extra = 0;
      for (int n = 0; n < 14; n++) begin
        @(posedge clk); #1;
        if (bus.done || bus.err) extra++;
      end
      n_tests++; if (extra != 0) begin n_fail++; $display("FAIL err%0d_once extra pulses %0d want 0", i, extra); end
    end
  endtask

  task automatic test_reset_mid();
    logic d, e; int lat, seen;
    @(negedge clk);
    bus.start = 1'b1; bus.dividen = 8'h35; bus.divisor = 8'h05;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_tests++; if (!(bus.Q === 8'h00 && bus.R === 8'h00 && bus.sign === 1'b0 && bus.done === 1'b0))
      begin n_fail++; $display("FAIL abort_clear Q=%h R=%h sign=%b done=%b want 00 00 0 0", bus.Q, bus.R, bus.sign, bus.done); end
    @(negedge clk); reset = 1'b1;
    seen = 0;
    for (int n = 0; n < 14; n++) begin
      @(posedge clk); #1;
      if (bus.done || bus.err) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL abort_quiet pulses %0d want 0", seen); end
    run_op(8'hCB, 8'h05, d, e, lat);
    n_tests++; if (!(d === 1'b1 && lat == 10 && bus.Q === 8'hF6 && bus.R === 8'hFD))
      begin n_fail++; $display("FAIL abort_restart done=%b lat=%0d Q=%h R=%h want 1 10 f6 fd", d, lat, bus.Q, bus.R); end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.dividen = 8'h35; bus.divisor = 8'hFB;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.dividen = 8'h03; bus.divisor = 8'h07;
    @(negedge clk); bus.start = 1'b0;
    lat = -1;
    for (int n = 5; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = n; break; end
    end
    n_tests++; if (!(lat == 10 && bus.Q === 8'hF6 && bus.R === 8'h03))
      begin n_fail++; $display("FAIL ignore_start lat=%0d Q=%h R=%h want 10 f6 03", lat, bus.Q, bus.R); end
    repeat (14) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int pulses, first, second;
    pulses = 0; first = -1; second = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.dividen = 8'h7F; bus.divisor = 8'h0A;
    @(posedge clk); #1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (n == 11) bus.start = 1'b0;
      if (bus.done) begin
        pulses++;
        if (first < 0) first = n; else second = n;
      end
    end
    n_tests++; if (!(pulses == 2 && first == 10 && second == 21))
      begin n_fail++; $display("FAIL back_to_back pulses=%0d at %0d,%0d want 2 at 10,21", pulses, first, second); end
    n_tests++; if (!(bus.Q === 8'h0C && bus.R === 8'h07))
      begin n_fail++; $display("FAIL back_to_back_val Q=%h R=%h want 0c 07", bus.Q, bus.R); end
  endtask

  initial begin
    bus.start = 1'b0; bus.dividen = 8'h00; bus.divisor = 8'h00;
    test_reset();
    test_signs();
    test_err();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
